// File: rtl/if_inst_fifo_pkg.sv
// Shared types for the IF->ID fetch buffer.
// Defines the 65-bit fetch entry and the NOP word.
package if_inst_fifo_pkg;

  localparam logic [31:0] FETCH_NOP = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        exc;
  } fetch_entry_t;

endpackage

// File: rtl/if_inst_fifo_if.sv
// Fetch buffer bundle: icache push side, decode pop side, status.
// master = IF/ID/controller side, slave = fifo.
interface if_inst_fifo_if #(
  parameter int CNT_W = 3
);
  logic             push_valid;
  logic [31:0]      push_pc;
  logic [31:0]      push_inst;
  logic             push_exc;
  logic             pop;
  logic             out_valid;
  logic [31:0]      out_pc;
  logic [31:0]      out_inst;
  logic             out_exc;
  logic             fifo_full;
  logic             almost_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] count;

  modport master (
    output push_valid, push_pc, push_inst,
    output push_exc, pop,
    input  out_valid, out_pc, out_inst, out_exc,
    input  fifo_full, almost_full, fifo_empty,
    input  count
  );

  modport slave (
    input  push_valid, push_pc, push_inst,
    input  push_exc, pop,
    output out_valid, out_pc, out_inst, out_exc,
    output fifo_full, almost_full, fifo_empty,
    output count
  );
endinterface

// File: rtl/if_inst_fifo_ptr.sv
// Wrapping pointer register with increment and clear.
// Ports: clk, resetn (sync, low), clr, inc, ptr.
module if_inst_fifo_ptr #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  always_ff @(posedge clk) begin
    if (!resetn || clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + W'(1);
    end
  end

endmodule

// File: rtl/if_inst_fifo.sv
// Show-ahead instruction buffer between IF and ID.
// Ports: clk, resetn (sync, low), flush, fif (slave bundle).
module if_inst_fifo
  import if_inst_fifo_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         flush,
  if_inst_fifo_if.slave fif
);

  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic [PTR_W:0]   cnt;
  logic             empty;
  logic             full;
  logic             pop_fire;
  logic             push_fire;
  fetch_entry_t     mem [DEPTH];
  fetch_entry_t     head;
  fetch_entry_t     wdata;

  // Status depends only on registered pointers.
  assign cnt   = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

  assign pop_fire  = fif.pop & ~empty;
  // A full fifo still takes a push when the head leaves.
  assign push_fire = fif.push_valid & (~full | pop_fire);

  if_inst_fifo_ptr #(.W(PTR_W+1)) u_wr_ptr (
    .clk    (clk),
    .resetn (resetn),
    .clr    (flush),
    .inc    (push_fire),
    .ptr    (wr_ptr)
  );

  if_inst_fifo_ptr #(.W(PTR_W+1)) u_rd_ptr (
    .clk    (clk),
    .resetn (resetn),
    .clr    (flush),
    .inc    (pop_fire),
    .ptr    (rd_ptr)
  );

  assign wdata.pc   = fif.push_pc;
  assign wdata.inst = fif.push_inst;
  assign wdata.exc  = fif.push_exc;

  always_ff @(posedge clk) begin
    if (resetn && !flush && push_fire) begin
      mem[wr_ptr[PTR_W-1:0]] <= wdata;
    end
  end

  assign head = mem[rd_ptr[PTR_W-1:0]];

  assign fif.out_valid   = ~empty;
  assign fif.out_pc      = empty ? 32'h0 : head.pc;
  assign fif.out_inst    = empty ? FETCH_NOP : head.inst;
  assign fif.out_exc     = ~empty & head.exc;
  assign fif.fifo_full   = full;
  assign fif.almost_full = (cnt >= (PTR_W+1)'(DEPTH-1));
  assign fif.fifo_empty  = empty;
  assign fif.count       = cnt;

endmodule

// File: tb/tb_if_inst_fifo.sv
// Randomized + directed bench for if_inst_fifo.
// Reference is a queue of entries with the fifo rules.
module tb_if_inst_fifo;
  import if_inst_fifo_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic clk;
  logic resetn;
  logic flush;

  int n_cmp;
  int n_err;

  fetch_entry_t q[$];

  if_inst_fifo_if #(.CNT_W(CW)) fif ();

  if_inst_fifo #(.DEPTH(DEPTH)) dut (
    .clk    (clk),
    .resetn (resetn),
    .flush  (flush),
    .fif    (fif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    int n;
    n = q.size();
    chk("count", 32'(fif.count), 32'(n));
    chk("empty", 32'(fif.fifo_empty), 32'(n == 0));
    chk("full", 32'(fif.fifo_full), 32'(n == DEPTH));
    chk("afull", 32'(fif.almost_full), 32'(n >= DEPTH-1));
    chk("valid", 32'(fif.out_valid), 32'(n != 0));
    if (n != 0) begin
      chk("pc", fif.out_pc, q[0].pc);
      chk("inst", fif.out_inst, q[0].inst);
      chk("exc", 32'(fif.out_exc), 32'(q[0].exc));
    end else begin
      chk("pc0", fif.out_pc, 32'h0);
      chk("inst0", fif.out_inst, 32'h0);
      chk("exc0", 32'(fif.out_exc), 32'h0);
    end
  endtask

  // One cycle: drive, check before edge, update model at edge.
  task automatic step(
    input bit          rn,
    input bit          fl,
    input bit          pv,
    input logic [31:0] pc,
    input logic [31:0] inst,
    input bit          ex,
    input bit          pp
  );
    bit popf;
    bit pushf;
    fetch_entry_t e;
    resetn         = rn;
    flush          = fl;
    fif.push_valid = pv;
    fif.push_pc    = pc;
    fif.push_inst  = inst;
    fif.push_exc   = ex;
    fif.pop        = pp;
    @(negedge clk);
    check_state();
    @(posedge clk);
    if (!rn || fl) begin
      q.delete();
    end else begin
      popf  = pp && (q.size() > 0);
      pushf = pv && ((q.size() < DEPTH) || popf);
      if (popf) void'(q.pop_front());
      if (pushf) begin
        e.pc   = pc;
        e.inst = inst;
        e.exc  = ex;
        q.push_back(e);
      end
    end
    #1;
  endtask

  task automatic idle();
    step(1, 0, 0, 32'h0, 32'h0, 0, 0);
  endtask

  task automatic push(input logic [31:0] pc);
    step(1, 0, 1, pc, ~pc, 0, 0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    resetn = 1'b0;
    flush = 1'b0;
    fif.push_valid = 1'b0;
    fif.push_pc = '0;
    fif.push_inst = '0;
    fif.push_exc = 1'b0;
    fif.pop = 1'b0;
    @(posedge clk);
    #1;
    step(0, 0, 0, 32'h0, 32'h0, 0, 0);

    // basic order
    step(1, 0, 1, 32'hBFC0_0000, 32'h0000_0000, 0, 0);
    step(1, 0, 1, 32'hBFC0_0004, 32'h2408_0001, 0, 0);
    idle();
    chk("two_cnt", 32'(fif.count), 32'd2);
    chk("two_pc", fif.out_pc, 32'hBFC0_0000);
    step(1, 0, 0, 32'h0, 32'h0, 0, 1);
    step(1, 0, 0, 32'h0, 32'h0, 0, 1);
    idle();

    // fill, drop, full push+pop
    push(32'h10);
    push(32'h20);
    push(32'h30);
    push(32'h40);
    push(32'h50);
    idle();
    chk("drop_cnt", 32'(fif.count), 32'd4);
    chk("drop_head", fif.out_pc, 32'h10);
    step(1, 0, 1, 32'h100, 32'hABCD, 0, 1);
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0, 32'h0, 32'h0, 0, 1);
    end

    // streaming pairs through the wrap
    push(32'h1000);
    for (int i = 1; i <= 10; i++) begin
      step(1, 0, 1, 32'h1000 + 32'(i*4), 32'(i), 0, 1);
    end
    step(1, 0, 0, 32'h0, 32'h0, 0, 1);
    idle();

    // flush with push and pop
    push(32'h200);
    push(32'h204);
    push(32'h208);
    step(1, 1, 1, 32'h20C, 32'h1234, 0, 1);
    idle();
    chk("fl_cnt", 32'(fif.count), 32'd0);
    chk("fl_inst", fif.out_inst, 32'h0);

    // pop on empty, push+pop on empty, exception flag
    step(1, 0, 0, 32'h0, 32'h0, 0, 1);
    step(1, 0, 1, 32'h300, 32'h77, 1, 1);
    idle();
    chk("exc_set", 32'(fif.out_exc), 32'd1);
    chk("exc_cnt", 32'(fif.count), 32'd1);

    // reset mid-stream
    push(32'h400);
    step(0, 0, 1, 32'h404, 32'h1, 0, 1);
    idle();

    // random traffic
    for (int i = 0; i < 800; i++) begin
      int r;
      bit rn;
      bit fl;
      r  = $urandom_range(0, 199);
      rn = (r != 0);
      fl = (r >= 1) && (r <= 6);
      step(rn, fl, 1'($urandom_range(0, 1)), $urandom,
           $urandom, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 2) == 0));
    end
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/if_inst_fifo.md
# if_inst_fifo

Instruction fetch buffer between the IF stage and the ID stage of the Gemini pipeline. It holds {pc, inst, exc} entries returned by the instruction cache. It presents the oldest entry to decode in show-ahead form and drains one entry per decode advance. It produces the `fifo_full` and `almost_full` indications consumed by the global pipeline controller, and it is cleared on branch redirect or exception.

## Interface
Parameters:
- `DEPTH`, default 4: number of entries; must be a power of two, ≥2.
- `PTR_W`, default `$clog2(DEPTH)`: pointer index width; not overridden.

Ports:
- `clk`, in, 1: clock; all state updates on the rising edge.
- `resetn`, in, 1: reset, synchronous, active-low.
- `flush`, in, 1: discard all entries; asserted on `ex_branch_taken` or `exp_detect`.
- `push_valid`, in, 1: icache returns an instruction this cycle.
- `push_pc`, in, 32: PC of the returned instruction.
- `push_inst`, in, 32: instruction word.
- `push_exc`, in, 1: fetch exception (AdEL) attached to this entry.
- `pop`, in, 1: decode consumes the head entry; driven by `en_if_id`.
- `out_valid`, out, 1: the head entry is valid.
- `out_pc`, out, 32: PC of the head entry.
- `out_inst`, out, 32: head instruction; 32'h0 (NOP) when empty.
- `out_exc`, out, 1: exception flag of the head entry; 0 when empty.
- `fifo_full`, out, 1: count == DEPTH.
- `almost_full`, out, 1: count ≥ DEPTH-1; IF stops issuing new fetches.
- `fifo_empty`, out, 1: count == 0.
- `count`, out, PTR_W+1: number of occupied entries.

## Operation
- Storage is a circular buffer of DEPTH × 65 bits. `wr_ptr` and `rd_ptr` are PTR_W+1 bits wide; the MSB is the wrap bit.
- `count = wr_ptr - rd_ptr`, computed modulo 2^(PTR_W+1).
- Full when the index bits of the two pointers are equal and the wrap bits differ. Empty when the pointers are identical.
- The head is read combinationally from `mem[rd_ptr[PTR_W-1:0]]` (show-ahead). `out_*` is gated to zero and `out_valid=0` when empty.
- `pop_fire = pop & ~fifo_empty`. A pop when empty is ignored and no pointer moves.
- `push_fire = push_valid & (~fifo_full | pop_fire)`. A push into a full FIFO in the same cycle as a pop is accepted. A push into a full FIFO without a pop is dropped. IF must respect `almost_full` so this never happens.
- Priority within a cycle: `resetn` low > `flush` > push/pop.
- `flush` sets `rd_ptr = wr_ptr = 0`. Any simultaneous push and pop are discarded, so the instruction fetched in the flush cycle is lost by design. The redirect PC is refetched by IF.
- Simultaneous push and pop on an empty FIFO: the pop is ignored (`pop_fire=0`) and the push is stored. `out_valid` rises next cycle; there is no bypass.
- Pointers wrap naturally through the MSB. No special case exists at `index = DEPTH-1`.

## Timing
- Reset values: `wr_ptr=0`, `rd_ptr=0`, `count=0`, `fifo_empty=1`, `fifo_full=0`, `almost_full=0`, `out_valid=0`, `out_inst=0`, `out_pc=0`, `out_exc=0`. Storage contents are not reset.
- Push-to-visible latency is 1 cycle: an entry pushed at edge N is on `out_*` after edge N, if it is the head.
- Pop takes effect at the edge. The next entry appears on `out_*` in the following cycle, with no bubble.
- `fifo_full`, `almost_full`, `fifo_empty` and `count` are derived combinationally from registered pointers only. They do not depend on the current `pop`/`push_valid`, so the global controller sees no combinational loop.
- After `flush` at edge N, `fifo_empty=1` from edge N onward.
- If `resetn` is deasserted in the middle of operation, reset behaves exactly like flush and additionally forces all reset values.

## Structure
- The shared `define.v` gains `` `FETCH_NOP 32'h0000_0000``. No other package constants are needed.
- There is one natural sub-module: `fifo_ptr`, a PTR_W+1 pointer register with increment and clear. It is instantiated twice (read and write).
- Storage is an inferred register array. No RAM macro is used.

## Test plan
- Reset, then push pc=0xBFC00000/0x00000000, 0xBFC00004/0x24080001 → after 2 edges `count=2`, `out_pc=0xBFC00000`; pop → `out_pc=0xBFC00004`.
- DEPTH=4: push 3 entries → `almost_full=1`, `fifo_full=0`; push 4th → `fifo_full=1`; 5th push with `pop=0` → dropped, `count=4`, head unchanged.
- Full FIFO with push and pop in the same cycle (new pc=0x100) → `count` stays 4, `fifo_full` stays 1, and 0x100 is popped fourth.
- 10 push/pop pairs through DEPTH=4 → pointers wrap, PCs come out strictly in order, `count` never exceeds 1.
- 3 entries, then `flush` with `push_valid=1` and `pop=1` → next cycle `count=0`, `out_valid=0`, `out_inst=0`; the pushed entry is absent.
- Pop on empty → no pointer change and `count` stays 0. Push with `push_exc=1` → `out_exc=1` next cycle.
